// File: rtl/pad_bank_ctrl_pkg.sv
// Shared definitions for the pad bank controller: register map, FSM states and
// attribute bit positions.
package pad_bank_ctrl_pkg;

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_OE     = 3'd1;
  localparam logic [2:0] REG_IN     = 3'd2;
  localparam logic [2:0] REG_PULL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int ATTR_PULL_BIT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    TURN = 1'b1
  } state_t;

endpackage

// File: rtl/pad_bank_ctrl_sync.sv
// WIDTH-bit, STAGES-deep flop synchronizer for asynchronous pad inputs.
module pad_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_stage[0] <= '0;
    else       r_stage[0] <= d_i;
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_stage[gi] <= '0;
      else       r_stage[gi] <= r_stage[gi-1];
    end
  end

  assign q_o = r_stage[STAGES-1];

endmodule

// File: rtl/pad_bank_ctrl.sv
// Register-programmed controller for a bank of bidirectional pads, with
// dead-cycle sequencing on newly enabled outputs and synchronized readback.
module pad_bank_ctrl
  import pad_bank_ctrl_pkg::*;
#(
  parameter int                    NUM_PADS    = 8,
  parameter int                    PADATTR     = 16,
  parameter int                    TURN_CYCLES = 2,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [NUM_PADS-1:0]   PULL_RST    = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          reg_req_i,
  input  logic                          reg_we_i,
  input  logic [2:0]                    reg_addr_i,
  input  logic [31:0]                   reg_wdata_i,
  output logic                          reg_gnt_o,
  output logic                          reg_rvalid_o,
  output logic [31:0]                   reg_rdata_o,
  output logic [NUM_PADS-1:0]           pad_in_o,
  output logic [NUM_PADS-1:0]           pad_oe_o,
  input  logic [NUM_PADS-1:0]           pad_out_i,
  output logic [NUM_PADS*PADATTR-1:0]   pad_attributes_o,
  output logic                          busy_o
);

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES == 0 ? 0 : TURN_CYCLES - 1);

  state_t              r_state, w_state_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic [NUM_PADS-1:0] r_pending, w_pending_next;
  logic [NUM_PADS-1:0] r_oe, w_oe_next;
  logic [NUM_PADS-1:0] r_out, r_pull;
  logic                r_rvalid;
  logic [31:0]         r_rdata;

  logic [NUM_PADS-1:0] w_wdata, w_in_sync, w_on;
  logic                w_oe_stall, w_wr, w_oe_wr;
  logic [31:0]         w_rd;
  logic                w_unused_wdata;

  assign w_wdata        = reg_wdata_i[NUM_PADS-1:0];
  assign w_unused_wdata = ^reg_wdata_i;

  // OE writes wait out an active turnaround; everything else is granted at once.
  assign w_oe_stall = reg_req_i & reg_we_i & (reg_addr_i == REG_OE) & (r_state == TURN);
  assign reg_gnt_o  = reg_req_i & ~w_oe_stall;
  assign w_wr       = reg_gnt_o & reg_we_i;
  assign w_oe_wr    = w_wr & (reg_addr_i == REG_OE);
  assign w_on       = ~r_oe & w_wdata;

  pad_sync #(
    .WIDTH  (NUM_PADS),
    .STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pad_out_i),
    .q_o   (w_in_sync)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out  <= '0;
      r_pull <= PULL_RST;
    end else if (w_wr) begin
      if (reg_addr_i == REG_OUT)  r_out  <= w_wdata;
      if (reg_addr_i == REG_PULL) r_pull <= w_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= '0;
      r_oe      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pending <= w_pending_next;
      r_oe      <= w_oe_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_pending_next = r_pending;
    w_oe_next      = r_oe;
    case (r_state)
      IDLE: begin
        if (w_oe_wr) begin
          if (w_on == '0 || TURN_CYCLES == 0) begin
            w_oe_next = w_wdata;
          end else begin
            // Release dropped pads now; newly enabled pads wait for the turnaround.
            w_oe_next      = r_oe & w_wdata;
            w_state_next   = TURN;
            w_cnt_next     = TURN_LOAD;
            w_pending_next = w_wdata;
          end
        end
      end
      TURN: begin
        if (r_cnt == '0) begin
          w_oe_next    = r_pending;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (r_state == TURN);
  end

  always_comb begin
    w_rd = '0;
    case (reg_addr_i)
      REG_OUT:    w_rd[NUM_PADS-1:0] = r_out;
      REG_OE:     w_rd[NUM_PADS-1:0] = r_oe;
      REG_IN:     w_rd[NUM_PADS-1:0] = w_in_sync;
      REG_PULL:   w_rd[NUM_PADS-1:0] = r_pull;
      REG_STATUS: w_rd[0]            = busy_o;
      default:    w_rd = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= reg_gnt_o;
      r_rdata  <= (reg_gnt_o && !reg_we_i) ? w_rd : 32'd0;
    end
  end

  assign reg_rvalid_o = r_rvalid;
  assign reg_rdata_o  = r_rdata;
  assign pad_in_o     = r_out;
  assign pad_oe_o     = r_oe;

  for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_attr
    logic [PADATTR-1:0] w_attr;
    always_comb begin
      w_attr                = '0;
      w_attr[ATTR_PULL_BIT] = r_pull[gi];
    end
    assign pad_attributes_o[gi*PADATTR +: PADATTR] = w_attr;
  end

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Directed bench for pad_bank_ctrl: table of single bus transactions followed by
// hand-timed turnaround, stall, readback and reset sequences.
module tb_pad_bank_ctrl;
  import pad_bank_ctrl_pkg::*;

  localparam int NP = 8;
  localparam int PA = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              reg_req_i = 1'b0;
  logic              reg_we_i = 1'b0;
  logic [2:0]        reg_addr_i = '0;
  logic [31:0]       reg_wdata_i = '0;
  logic              reg_gnt_o, reg_rvalid_o, busy_o;
  logic [31:0]       reg_rdata_o;
  logic [NP-1:0]     pad_in_o, pad_oe_o;
  logic [NP-1:0]     pad_out_i = '0;
  logic [NP*PA-1:0]  pad_attributes_o;

  int checks = 0;
  int errors = 0;

  pad_bank_ctrl #(
    .NUM_PADS    (NP),
    .PADATTR     (PA),
    .TURN_CYCLES (2),
    .SYNC_STAGES (2),
    .PULL_RST    (8'h24)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .reg_req_i        (reg_req_i),
    .reg_we_i         (reg_we_i),
    .reg_addr_i       (reg_addr_i),
    .reg_wdata_i      (reg_wdata_i),
    .reg_gnt_o        (reg_gnt_o),
    .reg_rvalid_o     (reg_rvalid_o),
    .reg_rdata_o      (reg_rdata_o),
    .pad_in_o         (pad_in_o),
    .pad_oe_o         (pad_oe_o),
    .pad_out_i        (pad_out_i),
    .pad_attributes_o (pad_attributes_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          we;
    logic [2:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic [NP-1:0] exp_pad_in;
    logic [NP-1:0] exp_oe;
    logic [NP-1:0] exp_pull;
  } vec_t;

  vec_t vecs [12];

  // Expected attribute bus: only bit 0 of each pad's field carries its pull enable.
  function automatic logic [NP*PA-1:0] attr_of(input logic [NP-1:0] pull);
    logic [NP*PA-1:0] a;
    a = '0;
    for (int p = 0; p < NP; p++) a[p*PA] = pull[p];
    return a;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One transaction: drive at negedge, sample gnt, return at the negedge after the grant edge.
  task automatic bus(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                     output logic gnt, output logic rv, output logic [31:0] rd);
    @(negedge clk_i);
    reg_req_i = 1'b1; reg_we_i = we; reg_addr_i = addr; reg_wdata_i = wd;
    #1 gnt = reg_gnt_o;
    @(posedge clk_i);
    @(negedge clk_i);
    rv = reg_rvalid_o; rd = reg_rdata_o;
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    $display("bus we=%0d addr=%0d wdata=%h -> gnt=%0d rvalid=%0d rdata=%h oe=%h busy=%0d",
             we, addr, wd, gnt, rv, rd, pad_oe_o, busy_o);
  endtask

  logic        g, rv;
  logic [31:0] rd;
  int          stalls;
  logic        granted;

  initial begin
    vecs[0]  = '{1'b1, REG_OUT,    32'h0000005A, 32'h0, 8'h5A, 8'h00, 8'h24};
    vecs[1]  = '{1'b0, REG_OUT,    32'h0,        32'h5A, 8'h5A, 8'h00, 8'h24};
    vecs[2]  = '{1'b0, REG_PULL,   32'h0,        32'h24, 8'h5A, 8'h00, 8'h24};
    vecs[3]  = '{1'b1, REG_PULL,   32'h00000081, 32'h0, 8'h5A, 8'h00, 8'h81};
    vecs[4]  = '{1'b0, REG_PULL,   32'h0,        32'h81, 8'h5A, 8'h00, 8'h81};
    vecs[5]  = '{1'b0, 3'd7,       32'h0,        32'h0, 8'h5A, 8'h00, 8'h81};
    vecs[6]  = '{1'b1, 3'd6,       32'h000000FF, 32'h0, 8'h5A, 8'h00, 8'h81};
    vecs[7]  = '{1'b0, REG_STATUS, 32'h0,        32'h0, 8'h5A, 8'h00, 8'h81};
    vecs[8]  = '{1'b1, REG_OE,     32'h00000000, 32'h0, 8'h5A, 8'h00, 8'h81};
    vecs[9]  = '{1'b0, REG_OE,     32'h0,        32'h0, 8'h5A, 8'h00, 8'h81};
    vecs[10] = '{1'b1, REG_OUT,    32'hFFFFFF3C, 32'h0, 8'h3C, 8'h00, 8'h81};
    vecs[11] = '{1'b0, REG_OUT,    32'h0,        32'h3C, 8'h3C, 8'h00, 8'h81};

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_oe", pad_oe_o, 8'h00);
    check("rst_pad_in", pad_in_o, 8'h00);
    check("rst_attr", pad_attributes_o, attr_of(8'h24));
    check("rst_rvalid", reg_rvalid_o, 1'b0);
    check("rst_rdata", reg_rdata_o, 32'h0);
    check("rst_busy", busy_o, 1'b0);
    rst_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].wdata, g, rv, rd);
      check($sformatf("vec%0d_gnt", i), g, 1'b1);
      check($sformatf("vec%0d_rvalid", i), rv, 1'b1);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_pad_in", i), pad_in_o, vecs[i].exp_pad_in);
      check($sformatf("vec%0d_oe", i), pad_oe_o, vecs[i].exp_oe);
      check($sformatf("vec%0d_attr", i), pad_attributes_o, attr_of(vecs[i].exp_pull));
    end
    check("pull81_attr_const", pad_attributes_o, 128'h0001_0000_0000_0000_0000_0000_0000_0001);

    // OE 0x00 -> 0x0F: two dead cycles, then enable
    bus(1'b1, REG_OE, 32'h0F, g, rv, rd);
    check("A_gnt", g, 1'b1);
    check("A_c1_oe", pad_oe_o, 8'h00);
    check("A_c1_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("A_c2_oe", pad_oe_o, 8'h00);
    check("A_c2_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("A_c3_oe", pad_oe_o, 8'h0F);
    check("A_c3_busy", busy_o, 1'b0);

    // OE 0x0F -> 0x3C: pads 0,1 released at once, pads 4,5 wait
    bus(1'b1, REG_OE, 32'h3C, g, rv, rd);
    check("B_c1_oe", pad_oe_o, 8'h0C);
    check("B_c1_busy", busy_o, 1'b1);
    @(negedge clk_i);
    check("B_c2_oe", pad_oe_o, 8'h0C);
    @(negedge clk_i);
    check("B_c3_oe", pad_oe_o, 8'h3C);
    check("B_c3_busy", busy_o, 1'b0);

    // OE write during busy stalls until busy falls
    bus(1'b1, REG_OE, 32'hFF, g, rv, rd);
    check("C_busy", busy_o, 1'b1);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = REG_OE; reg_wdata_i = 32'h3C;
    stalls = 0; granted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (reg_gnt_o) begin granted = 1'b1; break; end
      stalls++;
      @(negedge clk_i);
    end
    check("C_granted", granted, 1'b1);
    check("C_stall_cycles", stalls, 2);
    check("C_oe_before", pad_oe_o, 8'hFF);
    @(posedge clk_i);
    @(negedge clk_i);
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    check("C_rvalid", reg_rvalid_o, 1'b1);
    check("C_oe_after", pad_oe_o, 8'h3C);
    check("C_busy_after", busy_o, 1'b0);

    // OUT write during busy is granted and applied next cycle
    bus(1'b1, REG_OE, 32'h3F, g, rv, rd);
    bus_nowait_out();
    check("C2_oe_after", pad_oe_o, 8'h3F);

    // Off-only OE change: immediate, never busy
    bus(1'b1, REG_OE, 32'h03, g, rv, rd);
    check("D_oe", pad_oe_o, 8'h03);
    check("D_busy", busy_o, 1'b0);
    @(negedge clk_i);
    check("D_busy2", busy_o, 1'b0);

    // Synchronized input readback
    pad_out_i = 8'hA5;
    repeat (3) @(negedge clk_i);
    bus(1'b0, REG_IN, 32'h0, g, rv, rd);
    check("IN_rdata", rd, 32'hA5);
    check("IN_rvalid", rv, 1'b1);

    // Reset mid-turnaround
    bus(1'b1, REG_OE, 32'hFF, g, rv, rd);
    check("E_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("E_oe", pad_oe_o, 8'h00);
    check("E_pad_in", pad_in_o, 8'h00);
    check("E_attr", pad_attributes_o, attr_of(8'h24));
    check("E_rvalid", reg_rvalid_o, 1'b0);
    check("E_busy_rst", busy_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("E_oe_late", pad_oe_o, 8'h00);
    check("E_busy_late", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // OUT write issued the cycle after an OE write started a turnaround.
  task automatic bus_nowait_out();
    check("C2_busy", busy_o, 1'b1);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = REG_OUT; reg_wdata_i = 32'h99;
    #1;
    check("C2_out_gnt", reg_gnt_o, 1'b1);
    @(posedge clk_i);
    @(negedge clk_i);
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    $display("bus OUT write during busy -> pad_in=%h oe=%h busy=%0d", pad_in_o, pad_oe_o, busy_o);
    check("C2_pad_in", pad_in_o, 8'h99);
    check("C2_rvalid", reg_rvalid_o, 1'b1);
    check("C2_busy_still", busy_o, 1'b1);
    check("C2_oe_mid", pad_oe_o, 8'h3C);
    @(negedge clk_i);
  endtask

endmodule
